// File: rtl/pll_lock_mon_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the supervisor state enum, the shared-timer width helper and the
// statistics-counter saturation helper.
package pll_lock_mon_pkg;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } pll_mon_state_t;

  // Widest statistics counter the saturation helper can describe.
  localparam int unsigned CNT_W_MAX = 32;

  // One timer serves every state, so it is sized for the longest interval.
  function automatic int unsigned tmr_width(input int unsigned timeout_cyc,
                                            input int unsigned stable_cyc,
                                            input int unsigned rstpulse_cyc);
    int unsigned m;
    m = timeout_cyc;
    if (stable_cyc > m) m = stable_cyc;
    if (rstpulse_cyc > m) m = rstpulse_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // All-ones value of a w-bit counter: the value at which it stops counting.
  function automatic logic [CNT_W_MAX-1:0] cnt_sat_max(input int unsigned w);
    logic [CNT_W_MAX-1:0] v;
    if (w >= CNT_W_MAX) v = '1;
    else                v = (CNT_W_MAX'(1) << w) - CNT_W_MAX'(1);
    return v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Both flops clear on a synchronous active-low reset.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  // Two-stage capture; only the second stage is used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_lock_mon.sv
// PLL lock supervisor. Synchronises pll_lock, drives the PLL reset pulse,
// qualifies lock for STABLE_CYC cycles before releasing sys_rst_n, re-resets
// the PLL on acquisition timeout and re-asserts sys_rst_n on lock loss.
// Optional statistics counters are built when PLL_LOCK_MON_STAT_EN is
// defined; otherwise loss_cnt/timeout_cnt read as 0.
// dbg_state exposes the registered FSM state (pll_mon_state_t encoding).
module pll_lock_mon
  import pll_lock_mon_pkg::*;
#(
  parameter int unsigned STABLE_CYC   = 1024,
  parameter int unsigned TIMEOUT_CYC  = 65536,
  parameter int unsigned RSTPULSE_CYC = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             locked,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [1:0]       dbg_state
);

  localparam int unsigned TMR_W = tmr_width(TIMEOUT_CYC, STABLE_CYC, RSTPULSE_CYC);

  // Last timer value of each timed interval.
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RSTPULSE_CYC - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] ST_LAST  = TMR_W'(STABLE_CYC - 1);

  logic           lock_s;
  pll_mon_state_t state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state and shared-timer logic; every transition clears the timer.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      PLLRST: begin
        if (tmr_q == RST_LAST) begin
          state_d = WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      WAIT: begin
        if (lock_s) begin
          state_d = STABLE;
          tmr_d   = '0;
        end else if (tmr_q == TO_LAST) begin
          state_d = PLLRST;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT;
          tmr_d   = '0;
        end else if (tmr_q == ST_LAST) begin
          state_d = RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = PLLRST;
        tmr_d   = '0;
      end
    endcase
  end

  // State, timer and outputs register together, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PLLRST;
      tmr_q     <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pll_rst   <= (state_d == PLLRST);
      sys_rst_n <= (state_d == RUN);
      locked    <= (state_d == RUN);
    end
  end

  assign dbg_state = state_q;

`ifdef PLL_LOCK_MON_STAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_max(CNT_W));

  logic [CNT_W-1:0] loss_q, to_q;

  // Saturating event counters: loss leaves RUN, timeout leaves WAIT for PLLRST.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_q <= '0;
      to_q   <= '0;
    end else begin
      if (state_q == RUN && state_d == WAIT && loss_q != CNT_MAX)
        loss_q <= loss_q + CNT_W'(1);
      if (state_q == WAIT && state_d == PLLRST && to_q != CNT_MAX)
        to_q <= to_q + CNT_W'(1);
    end
  end

  assign loss_cnt    = loss_q;
  assign timeout_cnt = to_q;
`else
  assign loss_cnt    = '0;
  assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_mon.sv
// Bench for pll_lock_mon with STABLE_CYC=8, TIMEOUT_CYC=32, RSTPULSE_CYC=4,
// CNT_W=2. A behavioural model (pulse countdown, wait/qualify counts,
// released flag) predicts every output each cycle; directed literal checks
// pin reset, release edges, timeout and loss counting.
module tb_pll_lock_mon;

  localparam int S = 8;
  localparam int T = 32;
  localparam int R = 4;
  localparam int W = 2;
  localparam int CMAX = 3;
`ifdef PLL_LOCK_MON_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic         rst_n    = 1'b0;
  logic         pll_lock = 1'b0;
  logic         pll_rst, sys_rst_n, locked;
  logic [W-1:0] loss_cnt, timeout_cnt;
  logic [1:0]   dbg_state;

  pll_lock_mon #(
    .STABLE_CYC   (S),
    .TIMEOUT_CYC  (T),
    .RSTPULSE_CYC (R),
    .CNT_W        (W)
  ) dut (
    .clk         (clk_tb),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .locked      (locked),
    .loss_cnt    (loss_cnt),
    .timeout_cnt (timeout_cnt),
    .dbg_state   (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  bit m_valid = 0;
  bit m_s1 = 0, m_s2 = 0;   // lock after one / two edges
  int m_pulse = 0;          // PLL-reset cycles still to go
  int m_wait = 0;           // unlocked samples seen while acquiring
  int m_good = 0;           // locked samples seen while qualifying
  bit m_qual = 0;
  bit m_rel = 0;
  int m_loss = 0, m_to = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance at each edge, then per-cycle compare just after it.
  always @(posedge clk_tb) begin
    bit ls;
    ls = m_s2;
    if (!rst_n) begin
      m_valid = 1; m_s1 = 0; m_s2 = 0;
      m_pulse = R; m_wait = 0; m_good = 0; m_qual = 0; m_rel = 0;
      m_loss = 0; m_to = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = pll_lock;
      if (m_pulse > 0) begin
        m_pulse--;
        if (m_pulse == 0) begin m_wait = 0; m_qual = 0; m_rel = 0; end
      end else if (m_rel) begin
        if (!ls) begin m_rel = 0; m_wait = 0; m_loss = sat(m_loss + 1); end
      end else if (m_qual) begin
        if (!ls) begin m_qual = 0; m_wait = 0; end
        else begin
          m_good++;
          if (m_good == S) begin m_rel = 1; m_qual = 0; end
        end
      end else begin
        if (ls) begin m_qual = 1; m_good = 0; end
        else begin
          m_wait++;
          if (m_wait == T) begin m_to = sat(m_to + 1); m_pulse = R; end
        end
      end
    end
    #1;
    if (m_valid) begin
      check("cyc_pll_rst",   pll_rst,   (m_pulse > 0));
      check("cyc_sys_rst_n", sys_rst_n, m_rel);
      check("cyc_locked",    locked,    m_rel);
      check("cyc_loss_cnt",  loss_cnt,  STAT ? m_loss : 0);
      check("cyc_to_cnt",    timeout_cnt, STAT ? m_to : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_tb);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    cycles(n);
    rst_n = 1'b1;
  endtask

  // Bounded wait for the model's release flag to reach 'want'.
  task automatic wait_rel(input bit want, input int budget, input string name);
    int n;
    n = 0;
    while (m_rel !== want && n < budget) begin
      @(negedge clk_tb);
      n++;
    end
    n_vec++;
    if (m_rel !== want) begin
      n_err++;
      $display("FAIL %s: release flag stayed %0b, expected %0b within %0d cycles", name, m_rel, want, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1. Reset
    pll_lock = 1'b0;
    rst_n = 1'b0;
    cycles(3);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_locked", locked, 0);
    check("rst_loss_cnt", loss_cnt, 0);
    check("rst_to_cnt", timeout_cnt, 0);
    rst_n = 1'b1;
    cycles(3);
    check("pulse_hold_edge3", pll_rst, 1);
    cycles(1);
    check("pulse_end_edge4", pll_rst, 0);

    // 2. Clean lock from the first WAIT cycle
    pll_lock = 1'b1;
    cycles(10);
    check("pre_release_edge9", sys_rst_n, 0);
    cycles(1);
    check("release_edge10_sys", sys_rst_n, 1);
    check("release_edge10_lock", locked, 1);
    cycles(20);
    check("no_repulse", pll_rst, 0);

    // 3. One-cycle glitch while STABLE timer = 5
    pll_lock = 1'b0;
    do_reset(2);
    cycles(R);
    pll_lock = 1'b1;
    cycles(6);
    pll_lock = 1'b0;
    cycles(1);
    pll_lock = 1'b1;
    cycles(4);
    check("glitch_no_release_edge10", sys_rst_n, 0);
    cycles(6);
    check("glitch_pre_release_edge16", sys_rst_n, 0);
    cycles(1);
    check("glitch_release_edge17", sys_rst_n, 1);
    check("glitch_loss_cnt", loss_cnt, 0);

    // 4. Timeouts with lock held low
    pll_lock = 1'b0;
    do_reset(1);
    for (int k = 1; k <= 4; k++) begin
      cycles(R + T);
      check("timeout_cnt_step", timeout_cnt, STAT ? sat(k) : 0);
      check("timeout_repulse", pll_rst, 1);
    end

    // 5. Loss in RUN, then loss/re-lock until saturation
    pll_lock = 1'b1;
    wait_rel(1'b1, 100, "relock_after_timeouts");
    cycles($urandom_range(2, 10));
    pll_lock = 1'b0;
    cycles(2);
    check("loss_edge1_still_up", sys_rst_n, 1);
    cycles(1);
    check("loss_edge2_sys", sys_rst_n, 0);
    check("loss_edge2_locked", locked, 0);
    check("loss_edge2_cnt", loss_cnt, STAT ? 1 : 0);
    for (int k = 0; k < 3; k++) begin
      cycles($urandom_range(1, 10));
      pll_lock = 1'b1;
      wait_rel(1'b1, 100, "relock_loop");
      cycles($urandom_range(1, 15));
      pll_lock = 1'b0;
      wait_rel(1'b0, 10, "loss_loop");
    end
    cycles(3);
    check("loss_cnt_saturated", loss_cnt, STAT ? CMAX : 0);

    // Randomised lock activity with occasional resets
    for (int i = 0; i < 120; i++) begin
      pll_lock = $urandom_range(0, 1);
      cycles($urandom_range(1, 45));
      if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 3));
    end

    // 6. Reset while in RUN
    pll_lock = 1'b1;
    wait_rel(1'b1, 200, "reach_run_for_reset");
    cycles(3);
    rst_n = 1'b0;
    cycles(1);
    check("midrun_rst_pll_rst", pll_rst, 1);
    check("midrun_rst_sys", sys_rst_n, 0);
    check("midrun_rst_locked", locked, 0);
    check("midrun_rst_loss", loss_cnt, 0);
    check("midrun_rst_to", timeout_cnt, 0);
    rst_n = 1'b1;
    cycles(3);
    check("midrun_pulse_hold", pll_rst, 1);
    cycles(1);
    check("midrun_pulse_end", pll_rst, 0);
    cycles(15);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_mon.md
# pll_lock_mon

Lock supervisor sitting directly downstream of the `fft_pll` instance. It synchronises the asynchronous `pll_lock` into the `clkout0` domain and drives the PLL reset. It qualifies lock as stable before releasing the FFT datapath reset `sys_rst_n`. On lock-acquisition timeout it re-resets the PLL; on lock loss it re-asserts `sys_rst_n`.

## Interface
- `STABLE_CYC`, default 1024: consecutive synchronised-lock cycles required before release; must be ≥ 1.
- `TIMEOUT_CYC`, default 65536: cycles allowed in WAIT without lock before a PLL re-reset; must be ≥ 2.
- `RSTPULSE_CYC`, default 16: width in cycles of the `pll_rst` pulse; must be ≥ 1.
- `CNT_W`, default 8: width of the statistics counters.

Ports:
- `clk` in 1: free-running clock (`clkout0`).
- `rst_n` in 1: reset, synchronous, active-low.
- `pll_lock` in 1: raw PLL lock, asynchronous.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_rst_n` out 1: active-low reset for downstream logic.
- `locked` out 1: qualified-lock status.
- `loss_cnt` out `CNT_W`: saturating count of lock losses in RUN.
- `timeout_cnt` out `CNT_W`: saturating count of acquisition timeouts.

## Operation
- `pll_lock` passes through a 2-flop synchroniser to produce `lock_s`; both flops are 0 in reset.
- The FSM has four states: PLLRST, WAIT, STABLE, RUN. One shared timer `tmr` has width `$clog2(max(TIMEOUT_CYC, STABLE_CYC, RSTPULSE_CYC))`.
- **PLLRST**: `pll_rst`=1. The timer counts 0..`RSTPULSE_CYC`-1, then the FSM goes to WAIT with the timer cleared. `lock_s` is ignored.
- **WAIT**:
  - `lock_s`=1 → STABLE, timer cleared.
  - Otherwise the timer increments.
  - After exactly `TIMEOUT_CYC` cycles in WAIT with `lock_s`=0 → PLLRST, `timeout_cnt`++.
- **STABLE**:
  - `lock_s`=0 → WAIT, timer cleared. This is a glitch and no counter changes.
  - `lock_s`=1 with timer = `STABLE_CYC`-1 → RUN.
  - Otherwise the timer increments.
- **RUN**:
  - `sys_rst_n`=1 and `locked`=1.
  - `lock_s`=0 → WAIT, timer cleared, `loss_cnt`++.
- Counters saturate at 2^`CNT_W`-1 and never wrap.
- If a timeout and a loss would both apply in one cycle, the state priority makes this impossible (they occur only in distinct states).
- **Reset**: `rst_n`=0 at an edge forces PLLRST, timer 0, and synchroniser 0. This holds from any state, including mid-pulse and mid-RUN. Reset values after that edge:
  - `pll_rst`=1
  - `sys_rst_n`=0
  - `locked`=0
  - `loss_cnt`=0
  - `timeout_cnt`=0
- After `rst_n` returns to 1, `pll_rst` stays 1 for exactly `RSTPULSE_CYC` further edges.

## Timing
- All outputs are registered and update on the same edge as the state register. There is no combinational path from any input to any output.
- Edge numbering: edge 0 is the first edge that samples `pll_lock`=1 while in WAIT.
  - `lock_s`=1 after edge 1.
  - STABLE is entered at edge 2.
  - `sys_rst_n` and `locked` rise at edge `STABLE_CYC`+2, provided `pll_lock` stays 1.
- Lock loss: with edge 0 the first edge sampling `pll_lock`=0 in RUN, `sys_rst_n`=0 and `locked`=0 from edge 2. `loss_cnt` updates on the same edge.
- `pll_rst` pulses are exactly `RSTPULSE_CYC` cycles. The minimum gap between two pulses is `TIMEOUT_CYC` cycles.

## Configuration
- Macro: `PLL_LOCK_MON_STAT_EN`.
- Defined: the `loss_cnt` and `timeout_cnt` registers are built and behave as described above.
- Undefined: both ports remain present but are tied to 0, and no counter flops are synthesised. FSM and timing are otherwise identical.

## Structure
- `pll_lock_mon_pkg` holds:
  - the `pll_mon_state_t` enum (PLLRST, WAIT, STABLE, RUN);
  - the timer-width localparam function;
  - the shared counter-saturation constants.
- Sub-module `sync_2ff`: a generic 2-flop synchroniser with synchronous active-low reset. It is reused elsewhere for other asynchronous status inputs.

## Test plan
Bench parameters: `STABLE_CYC`=8, `TIMEOUT_CYC`=32, `RSTPULSE_CYC`=4, `CNT_W`=2.
1. **Reset**: hold `rst_n`=0 for 3 cycles → `pll_rst`=1, `sys_rst_n`=0, `locked`=0, both counters 0. After release, `pll_rst` stays 1 for exactly 4 edges, then 0.
2. **Clean lock**: `pll_lock`=1 from the first WAIT cycle → `sys_rst_n` and `locked` rise at edge 10. `pll_rst` does not pulse again.
3. **Glitch in STABLE**: `pll_lock` low for 1 cycle at STABLE timer = 5 → no release at edge 10. Release comes 8 `lock_s` cycles after re-lock; `loss_cnt` stays 0.
4. **Timeout**: `pll_lock` held 0 → `pll_rst` pulses 4 cycles after every 32 WAIT cycles. `timeout_cnt` reads 1, 2, 3, then stays 3 on the 4th timeout.
5. **Loss in RUN**: drop `pll_lock` in RUN → `sys_rst_n`=0 two edges later and `loss_cnt`=1. Four loss/re-lock cycles → `loss_cnt` saturates at 3.
6. **Reset mid-RUN**: `rst_n`=0 for 1 cycle while in RUN → next edge gives all reset values, counters 0, and a fresh 4-cycle `pll_rst` pulse after release.
